// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: source indices, register-index
// width, default data width and the round-robin pointer helper.
package wb_arbiter_pkg;

    // Result source indices
    localparam int SRC_ALU  = 0;
    localparam int SRC_MUL  = 1;
    localparam int SRC_MEM  = 2;
    localparam int NSRC_DEF = 3;

    // Architectural register index width and default result width
    localparam int REG_W  = 5;
    localparam int DATA_W = 64;

    typedef logic [REG_W-1:0] reg_idx_t;

    // Round-robin successor of source index s among n sources
    function automatic int rr_next(input int s, input int n);
        return (s + 1) % n;
    endfunction

endpackage

// File: rtl/wb_arbiter_slot.sv
// wb_slot: single-entry result buffer for one functional unit. Accepts a
// result when valid & ready, drops x0 results, drains on grant and empties
// on kill. A new transfer takes priority over the drain of the same edge.
module wb_slot
    import wb_arbiter_pkg::*;
#(
    parameter int DW = DATA_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          kill_i,
    input  logic          valid_i,
    input  reg_idx_t      dst_i,
    input  logic [DW-1:0] data_i,
    input  logic          drain_i,
    output logic          ready_o,
    output logic          full_o,
    output reg_idx_t      dst_o,
    output logic [DW-1:0] data_o
);

    logic          full_q, full_d;
    reg_idx_t      dst_q, dst_d;
    logic [DW-1:0] data_q, data_d;
    logic          load;

    // Ready never looks at valid_i: free, draining this edge, or being flushed
    assign ready_o = ~full_q | drain_i | kill_i;

    // x0 results complete the handshake but never occupy the slot
    assign load = valid_i & ready_o & ~kill_i & (dst_i != '0);

    // Next-state selection: kill beats load, load beats drain
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a latch.
        full_d = full_q;
        dst_d  = dst_q;
        data_d = data_q;
        if (kill_i) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            dst_d  = dst_i;
            data_d = data_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    // Slot state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: payload is reset as well; it is one entry, and this keeps the
        // slot outputs free of X before the first transfer.
        if (rst_i) begin
            full_q <= 1'b0;
            dst_q  <= '0;
            data_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            full_q <= full_d;
            dst_q  <= dst_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign dst_o  = dst_q;
    assign data_o = data_q;

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: buffers one result per functional unit and drives the single
// registered writeback port, arbitrating round-robin over full slots.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NSRC = NSRC_DEF,
    parameter int DW   = DATA_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  kill_i,
    input  logic [NSRC-1:0]       src_valid_i,
    output logic [NSRC-1:0]       src_ready_o,
    input  logic [REG_W*NSRC-1:0] src_dst_i,
    input  logic [DW*NSRC-1:0]    src_data_i,
    output logic                  wb_we_o,
    output logic [REG_W-1:0]      wb_dst_o,
    output logic [DW-1:0]         wb_data_o
);

    localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0] slot_full;
    reg_idx_t        slot_dst  [NSRC];
    logic [DW-1:0]   slot_data [NSRC];

    logic [NSRC-1:0] grant;
    logic            found;
    int              win;

    reg_idx_t        win_dst;
    logic [DW-1:0]   win_data;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             wb_we_q, wb_we_d;
    reg_idx_t         wb_dst_q, wb_dst_d;
    logic [DW-1:0]    wb_data_q, wb_data_d;

    for (genvar s = 0; s < NSRC; s++) begin : g_slot
        wb_slot #(.DW(DW)) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .kill_i  (kill_i),
            .valid_i (src_valid_i[s]),
            .dst_i   (src_dst_i[REG_W*s +: REG_W]),
            .data_i  (src_data_i[DW*s +: DW]),
            .drain_i (grant[s]),
            .ready_o (src_ready_o[s]),
            .full_o  (slot_full[s]),
            .dst_o   (slot_dst[s]),
            .data_o  (slot_data[s])
        );
    end

    // Round-robin search: first full slot at or after rr_ptr, wrapping
    always_comb begin
        int idx;
        grant = '0;
        found = 1'b0;
        win   = 0;
        idx   = 0;
        for (int i = 0; i < NSRC; i++) begin
            idx = (int'(rr_ptr_q) + i) % NSRC;
            if (!found && slot_full[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = idx;
            end
        end
    end

    // One-hot AND-OR select of the winning slot payload
    always_comb begin
        win_dst  = '0;
        win_data = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (grant[s]) begin
                win_dst  = win_dst | slot_dst[s];
                win_data = win_data | slot_data[s];
            end
        end
    end

    // Next output and pointer state; a kill suppresses the grant's effect
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        wb_we_d   = 1'b0;
        wb_dst_d  = wb_dst_q;
        wb_data_d = wb_data_q;
        if (found && !kill_i) begin
            rr_ptr_d  = PTR_W'(rr_next(win, NSRC));
            wb_we_d   = 1'b1;
            wb_dst_d  = win_dst;
            wb_data_d = win_data;
        end
    end

    // Writeback port and round-robin pointer registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q  <= '0;
            wb_we_q   <= 1'b0;
            wb_dst_q  <= '0;
            wb_data_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wb_we_q   <= wb_we_d;
            wb_dst_q  <= wb_dst_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_we_o   = wb_we_q;
    assign wb_dst_o  = wb_dst_q;
    assign wb_data_o = wb_data_q;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter: collects completed results from NSRC functional units (ALU, MUL/DIV, MEM) through per-unit valid/ready handshakes. It buffers one result per unit and drives the single registered writeback port (wb_we, wb_dst, wb_data). That port feeds the register file and the exe-stage bypass network. It sits at the end of the exe stage, between the functional units and the register file.

## Interface
Parameters:
- NSRC, 3, number of result sources (legal 2..4); index 0 = ALU, 1 = MUL/DIV, 2 = MEM.
- DW, 64, data width; must equal the width of the `DATA` macro from definitions.v.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- kill_i  in  1  pipeline flush; discards all buffered and in-flight results.
- src_valid_i  in  NSRC  per-source result valid.
- src_ready_o  out  NSRC  per-source ready; a transfer occurs when valid & ready.
- src_dst_i  in  5*NSRC  per-source destination register; source s at bits [5s+4:5s].
- src_data_i  in  DW*NSRC  per-source result data; source s at bits [DW*s+DW-1:DW*s].
- wb_we_o  out  1  registered writeback enable.
- wb_dst_o  out  5  registered writeback destination.
- wb_data_o  out  DW  registered writeback data.

## Operation
- Each source has a one-entry slot holding full, dst and data.
- src_ready_o[s] = ~full[s] | grant[s] | kill_i.
  - Combinational from slot state, arbitration and kill_i only.
  - Never depends on src_valid_i.
- Accept rule:
  - A transfer with dst != 0 loads the slot.
  - A transfer with dst == 0 (x0) is consumed, i.e. ready honoured, but the slot is not filled. No write is ever produced for x0.
- Arbitration is round-robin over full slots.
  - rr_ptr is log2(NSRC) bits, reset 0.
  - The search starts at rr_ptr and wraps modulo NSRC; the first full slot found wins (one-hot grant).
  - After a grant to s, rr_ptr <= (s+1) mod NSRC. With no grant, rr_ptr holds.
- Output register, loaded every edge:
  - On grant: wb_we_o <= 1, and wb_dst_o/wb_data_o <= winner slot contents.
  - With no grant: wb_we_o <= 0; wb_dst_o and wb_data_o hold their previous value.
- The granted slot is cleared at the same edge, unless a new transfer for that source refills it at the same edge. A new transfer wins over the clear.
- Kill (kill_i = 1 at an edge):
  - All full bits are cleared and wb_we_o <= 0.
  - Any transfer in that cycle is discarded; rr_ptr holds.
  - No grant takes effect that cycle.
- The block does not order writes to the same dst from different sources; issue logic guarantees this never happens.

## Timing
- Reset values: wb_we_o = 0, wb_dst_o = 0, wb_data_o = 0, all full = 0, rr_ptr = 0. Hence src_ready_o = all ones during and after reset.
- Latency:
  - Transfer in cycle N → slot full in N+1.
  - If it wins in N+1, wb_we_o = 1 in N+2 with that dst/data.
  - Minimum latency is 2 cycles.
- Throughput:
  - A lone source sustains 1 result/cycle (simultaneous drain and refill).
  - Aggregate throughput is 1 write/cycle.
- With k sources continuously full, each is granted exactly once every k cycles; no source waits more than NSRC-1 cycles once full.
- A full, non-granted slot holds src_ready_o = 0; the source must hold valid, dst and data stable until ready.
- Reset mid-operation drops all slots and the output immediately (asynchronous); no write completes.

## Structure
- Source index constants (SRC_ALU = 0, SRC_MUL = 1, SRC_MEM = 2) and NSRC default go in definitions.v alongside `DATA`. The register-index width (5) is a shared constant there.
- One sub-module, wb_slot: a single-entry buffer with full flag, accept/drain/kill inputs and ready output, instantiated NSRC times.
- Round-robin search and the output register live in wb_arbiter.

## Test plan
- Reset then idle: after rst_i deassert, src_ready_o = 3'b111, wb_we_o = 0, wb_dst_o = 0, wb_data_o = 0 for 10 cycles.
- Single transfer: ALU dst = 5, data = 0xDEAD in cycle 0 → wb_we_o = 1, wb_dst_o = 5, wb_data_o = 0xDEAD in cycle 2 only; wb_we_o = 0 in cycle 3.
- Three-way contention: all sources valid with dsts 1/2/3 each cycle, held 9 cycles from reset → write order ALU, MUL, MEM repeating. Each source sees src_ready_o = 1 once per 3 cycles, and no write is lost or duplicated.
- x0 drop: MUL dst = 0, data = 0x1234 → ready = 1, no wb_we_o pulse; a following MUL dst = 7 transfer is written 2 cycles later.
- Kill: fill all three slots, assert kill_i for 1 cycle, with an ALU transfer (dst = 9) in the same cycle → no wb_we_o pulse thereafter, dst 9 never written, all ready = 1.
- Streaming: MEM valid every cycle, dsts 1..8, others idle → 8 consecutive wb_we_o cycles, dsts 1..8 in order, src_ready_o[2] constantly 1.
